tiger_sdram_arbiter: RTL and testbench

//  Two-master Avalon-MM arbiter sharing the single SDRAM controller port of the tiger system

---
 rtl/tiger_sdram_arbiter_if.sv | 25 ++
 rtl/tiger_sdram_arbiter.sv | 130 +++++++++++++
 tb/tb_tiger_sdram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiger_sdram_arbiter_if.sv
// Single-word Avalon-MM port bundle shared by the two refill masters and the SDRAM controller side.
// "master" is the side that issues requests, "slave" is the side that services them.
interface tiger_sdram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/tiger_sdram_arbiter.sv
// Round-robin arbiter putting the instruction (m0) and data (m1) refill masters onto one SDRAM port;
// a tag FIFO of owner ids routes pipelined read returns back to whichever master issued them.
module tiger_sdram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic clk,
    input  logic reset,
    tiger_sdram_arbiter_if.slave  m0,
    tiger_sdram_arbiter_if.slave  m1,
    tiger_sdram_arbiter_if.master s,
    output logic err_underflow
);
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state_q;
    logic              last_owner_q;
    logic [CNT_W-1:0]  pend_cnt_q;
    logic [CNT_W-1:0]  pend_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic              err_q;
    logic              tag_mem [MAX_PEND];

    logic own0, own1, req0, req1;
    logic own_read, own_write, full, rd_block;
    logic accept, push, pop, has_pend, head_tag;

    assign own0      = (state_q == OWN0);
    assign own1      = (state_q == OWN1);
    assign req0      = m0.read | m0.write;
    assign req1      = m1.read | m1.write;
    assign own_read  = (own0 & m0.read)  | (own1 & m1.read);
    assign own_write = (own0 & m0.write) | (own1 & m1.write);

    // Full is judged on the registered count, so a same-cycle return never unblocks a read.
    assign full      = (pend_cnt_q == CNT_W'(MAX_PEND));
    assign rd_block  = own_read & full;

    assign s.read       = own_read & ~full;
    assign s.write      = own_write;
    assign s.address    = own1 ? m1.address    : m0.address;
    assign s.writedata  = own1 ? m1.writedata  : m0.writedata;
    assign s.byteenable = own1 ? m1.byteenable : m0.byteenable;

    assign accept   = (s.read | s.write) & ~s.waitrequest;
    assign push     = s.read & ~s.waitrequest;
    assign has_pend = (pend_cnt_q != '0);
    assign pop      = s.readdatavalid & has_pend;
    assign head_tag = tag_mem[rd_ptr_q];

    assign m0.waitrequest   = own0 ? (s.waitrequest | rd_block) : 1'b1;
    assign m1.waitrequest   = own1 ? (s.waitrequest | rd_block) : 1'b1;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = pop & ~head_tag;
    assign m1.readdatavalid = pop & head_tag;
    assign err_underflow    = err_q;

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        case ({push, pop})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    // Tag storage needs no reset: validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= own1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            pend_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (s.readdatavalid & ~has_pend) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (req0 & req1) begin
                        state_q <= last_owner_q ? OWN0 : OWN1;
                    end else if (req0) begin
                        state_q <= OWN0;
                    end else if (req1) begin
                        state_q <= OWN1;
                    end
                end
                OWN0: begin
                    if (accept) begin
                        last_owner_q <= 1'b0;
                        state_q      <= req1 ? OWN1 : OWN0;
                    end else if (!req0) begin
                        state_q <= req1 ? OWN1 : IDLE;
                    end
                end
                OWN1: begin
                    if (accept) begin
                        last_owner_q <= 1'b1;
                        state_q      <= req0 ? OWN0 : OWN1;
                    end else if (!req1) begin
                        state_q <= req0 ? OWN0 : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tiger_sdram_arbiter.sv
// Self-checking bench for tiger_sdram_arbiter: cycle vector table, hand-written corner
// sequences, and randomized traffic scored against a transaction-level controller model.
module tb_tiger_sdram_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_PEND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_underflow;

    always #5 clk = ~clk;

    tiger_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    tiger_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    tiger_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    tiger_sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
        .clk           (clk),
        .reset         (rst),
        .m0            (m0_bus),
        .m1            (m1_bus),
        .s             (s_bus),
        .err_underflow (err_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = 32'h100;
        m0_bus.writedata = 32'h0; m0_bus.byteenable = 4'hF;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = 32'h200;
        m1_bus.writedata = 32'h0; m1_bus.byteenable = 4'hF;
        s_bus.waitrequest = 1'b0; s_bus.readdatavalid = 1'b0; s_bus.readdata = 32'hDEADBEEF;
    endtask

    // Leaves the bench at a falling edge with reset released and the arbiter in IDLE.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle vectors: inputs {m0_read,m0_write,m1_read,m1_write,s_waitrequest,s_readdatavalid},
    // expected {s_read,s_write,m0_wait,m1_wait,m0_rdv,m1_rdv,err_underflow} and s_address.
    typedef struct {
        logic [5:0]  in;
        logic [6:0]  exp;
        logic [31:0] addr;
    } vec_t;
    vec_t vecs[13];

    // Randomized traffic model: each master holds one request until accepted; the controller
    // returns reads in issue order after a random latency, remembering who issued each one.
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } ret_t;
    ret_t        ctrl_q[$];
    logic        act[2];
    logic        isrd[2];
    logic [31:0] maddr[2];
    logic [31:0] mwd[2];
    logic [3:0]  mbe[2];
    int          cyc_n = 0;

    task automatic random_cycle(input bit allow_new);
        logic acc0, acc1, sacc, who;
        int   pend_before;
        ret_t r;
        for (int m = 0; m < 2; m++) begin
            if (allow_new && !act[m] && $urandom_range(0, 2) == 0) begin
                act[m]   = 1'b1;
                isrd[m]  = 1'($urandom_range(0, 1));
                maddr[m] = $urandom;
                mwd[m]   = $urandom;
                mbe[m]   = 4'($urandom);
            end
        end
        m0_bus.read = act[0] & isrd[0];  m0_bus.write = act[0] & ~isrd[0];
        m0_bus.address = maddr[0]; m0_bus.writedata = mwd[0]; m0_bus.byteenable = mbe[0];
        m1_bus.read = act[1] & isrd[1];  m1_bus.write = act[1] & ~isrd[1];
        m1_bus.address = maddr[1]; m1_bus.writedata = mwd[1]; m1_bus.byteenable = mbe[1];
        s_bus.waitrequest = ($urandom_range(0, 3) == 0);
        if (ctrl_q.size() > 0 && ctrl_q[0].due <= cyc_n) begin
            s_bus.readdatavalid = 1'b1;
            s_bus.readdata      = ctrl_q[0].data;
        end else begin
            s_bus.readdatavalid = 1'b0;
            s_bus.readdata      = $urandom;
        end
        #1;
        acc0 = (m0_bus.read | m0_bus.write) & ~m0_bus.waitrequest;
        acc1 = (m1_bus.read | m1_bus.write) & ~m1_bus.waitrequest;
        sacc = (s_bus.read | s_bus.write) & ~s_bus.waitrequest;
        pend_before = ctrl_q.size();
        check("accept_one", 96'(sacc), 96'(acc0 ^ acc1));
        who = acc1;
        if (sacc) begin
            check("s_request",
                  {s_bus.address, s_bus.read, s_bus.write, s_bus.writedata, s_bus.byteenable},
                  {maddr[who], isrd[who], ~isrd[who], mwd[who], mbe[who]});
        end
        if (s_bus.readdatavalid) begin
            r = ctrl_q.pop_front();
            check("rdv_route", {m0_bus.readdatavalid, m1_bus.readdatavalid, m0_bus.readdata, m1_bus.readdata},
                  {~r.id, r.id, r.data, r.data});
        end else begin
            check("no_rdv", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 96'd0);
        end
        if (sacc && s_bus.read) begin
            check("pend_limit", 96'(pend_before < MAX_PEND), 96'd1);
            r.id   = who;
            r.data = maddr[who] ^ 32'hA5A5_0F0F;
            r.due  = cyc_n + int'($urandom_range(1, 6));
            ctrl_q.push_back(r);
        end
        if (acc0) act[0] = 1'b0;
        if (acc1) act[1] = 1'b0;
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        int issued;
        vecs[0]  = '{6'b100000, 7'b0011000, 32'h100};
        vecs[1]  = '{6'b100000, 7'b1001000, 32'h100};
        vecs[2]  = '{6'b001000, 7'b0001000, 32'h100};
        vecs[3]  = '{6'b001010, 7'b1011000, 32'h200};
        vecs[4]  = '{6'b001001, 7'b1010100, 32'h200};
        vecs[5]  = '{6'b010001, 7'b0010010, 32'h200};
        vecs[6]  = '{6'b010000, 7'b0101000, 32'h100};
        vecs[7]  = '{6'b000001, 7'b0001000, 32'h100};
        vecs[8]  = '{6'b010100, 7'b0011001, 32'h100};
        vecs[9]  = '{6'b010100, 7'b0110001, 32'h200};
        vecs[10] = '{6'b010100, 7'b0101001, 32'h100};
        vecs[11] = '{6'b000000, 7'b0010001, 32'h200};
        vecs[12] = '{6'b000000, 7'b0011001, 32'h100};

        idle_inputs();
        do_reset();
        #1;
        check("reset_state", {s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest, err_underflow},
              96'b00110);

        // Table-driven cycle vectors from a fresh reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            m0_bus.read = vecs[i].in[5]; m0_bus.write = vecs[i].in[4];
            m1_bus.read = vecs[i].in[3]; m1_bus.write = vecs[i].in[2];
            s_bus.waitrequest = vecs[i].in[1]; s_bus.readdatavalid = vecs[i].in[0];
            #1;
            $display("vector %0d: in=%b out=%b%b%b%b%b%b%b addr=%h", i, vecs[i].in,
                     s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest,
                     m0_bus.readdatavalid, m1_bus.readdatavalid, err_underflow, s_bus.address);
            check($sformatf("vec%0d", i),
                  {s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest,
                   m0_bus.readdatavalid, m1_bus.readdatavalid, err_underflow, s_bus.address},
                  {vecs[i].exp, vecs[i].addr});
            @(negedge clk);
        end

        // Both masters streaming writes: strict alternation starting with m0, no bubbles.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            m0_bus.write = 1'b1; m1_bus.write = 1'b1;
            #1;
            if (c > 0) begin
                check($sformatf("rr_grant%0d", c),
                      {s_bus.write, ~m0_bus.waitrequest, ~m1_bus.waitrequest},
                      (c % 2 == 1) ? 96'b110 : 96'b101);
            end
            @(negedge clk);
        end
        idle_inputs();

        // Five back-to-back reads from m0; the first return comes 10 cycles after its accept.
        do_reset();
        issued = 0;
        for (int c = 0; c < 13; c++) begin
            m0_bus.read = 1'b1;
            m0_bus.address = 32'h1000 + 32'(issued * 4);
            s_bus.readdatavalid = (c == 11);
            #1;
            if (c >= 5 && c <= 11) begin
                check($sformatf("full_hold%0d", c), {s_bus.read, m0_bus.waitrequest}, 96'b01);
            end
            if (c == 11) begin
                check("full_return", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 96'b10);
            end
            if (c == 12) begin
                check("full_release", {s_bus.read, m0_bus.waitrequest, s_bus.address},
                      {2'b10, 32'h1010});
            end
            if (!m0_bus.waitrequest) issued++;
            @(negedge clk);
        end
        idle_inputs();

        // Underflow is sticky; a mid-cycle reset with reads in flight clears everything.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            s_bus.readdatavalid = (c == 0);
            m0_bus.read = 1'b1;
            #1;
            if (c == 0) begin
                check("underflow_no_valid", {m0_bus.readdatavalid, m1_bus.readdatavalid}, 96'b00);
            end
            @(negedge clk);
        end
        m0_bus.read = 1'b0;
        s_bus.readdatavalid = 1'b0;
        #1;
        check("err_sticky", 96'(err_underflow), 96'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", {s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest, err_underflow},
              96'b00110);
        @(negedge clk);
        rst = 1'b0;
        m1_bus.read = 1'b1;
        #1;
        check("post_reset_idle", {s_bus.read, m1_bus.waitrequest}, 96'b01);
        @(negedge clk);
        #1;
        check("post_reset_grant", {s_bus.read, m1_bus.waitrequest, s_bus.address}, {2'b10, 32'h200});
        @(negedge clk);
        m1_bus.read = 1'b0;
        s_bus.readdatavalid = 1'b1;
        s_bus.readdata = 32'hDEADBEEF;
        #1;
        check("post_reset_return",
              {m0_bus.readdatavalid, m1_bus.readdatavalid, m0_bus.readdata, m1_bus.readdata, err_underflow},
              {2'b01, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        s_bus.readdatavalid = 1'b0;
        #1;
        check("post_reset_no_err", 96'(err_underflow), 96'd0);

        // Randomized traffic against the controller/scoreboard model.
        do_reset();
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; isrd[m] = 1'b0; maddr[m] = '0; mwd[m] = '0; mbe[m] = '0;
        end
        for (int k = 0; k < 3000; k++) begin
            random_cycle(1'b1);
        end
        for (int k = 0; k < 300 && (act[0] || act[1] || ctrl_q.size() > 0); k++) begin
            random_cycle(1'b0);
        end
        check("drain_empty", {act[0], act[1], 1'(ctrl_q.size() == 0), err_underflow}, 96'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
